// File: rtl/huffman_seq.sv
// Job sequencer for the six-symbol huffman core: clears the core, streams one
// ROM frame into it, captures counts/codes/masks and returns them per symbol.
module huffman_seq #(
  parameter int N_PIX   = 100,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic              core_reset,
  output logic              gray_valid,
  output logic [7:0]        gray_data,
  input  logic              CNT_valid,
  input  logic [47:0]       cnt_bus,
  input  logic              code_valid,
  input  logic [47:0]       hc_bus,
  input  logic [47:0]       m_bus,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_sym,
  output logic [7:0]        res_cnt,
  output logic [7:0]        res_hc,
  output logic [7:0]        res_m
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
  localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLR       = 3'd1,
    S_FETCH     = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_CNT  = 3'd4,
    S_WAIT_CODE = 3'd5,
    S_OUT       = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [2:0]        sym_q, sym_d;
  logic [47:0]       cnt_q, cnt_d, hc_q, hc_d, m_q, m_d;
  logic              done_q, done_d;
  logic              core_reset_q;

  function automatic logic [7:0] sym_field(input logic [47:0] bus, input logic [2:0] sym);
    case (sym)
      3'd1:    sym_field = bus[7:0];
      3'd2:    sym_field = bus[15:8];
      3'd3:    sym_field = bus[23:16];
      3'd4:    sym_field = bus[31:24];
      3'd5:    sym_field = bus[39:32];
      3'd6:    sym_field = bus[47:40];
      default: sym_field = 8'd0;
    endcase
  endfunction

  // Next-state logic plus the ROM/core streaming strobes.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    wd_d       = wd_q;
    err_code_d = err_code_q;
    sym_d      = sym_q;
    cnt_d      = cnt_q;
    hc_d       = hc_q;
    m_d        = m_q;
    done_d     = 1'b0;
    rom_rd     = 1'b0;
    rom_addr   = '0;
    gray_valid = 1'b0;
    gray_data  = 8'd0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_CLR;
          p_d        = '0;
          wd_d       = '0;
          err_code_d = 2'b00;
        end else begin
          state_d = state_q;
        end
      end
      // p doubles as the two-cycle core-reset timer.
      S_CLR: begin
        if (p_q == ONE_A) begin
          state_d = S_FETCH;
          p_d     = '0;
        end else begin
          p_d = p_q + ONE_A;
        end
      end
      S_FETCH: begin
        rom_rd  = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        gray_data = rom_q;
        if (p_q != LAST_PIX) begin
          rom_rd   = 1'b1;
          rom_addr = p_q + ONE_A;
        end else begin
          rom_rd = 1'b0;
        end
        if (rom_q == 8'd0 || rom_q > 8'd6) begin
          err_code_d = 2'b01;
          state_d    = S_ERR;
        end else if (p_q == LAST_PIX) begin
          gray_valid = 1'b1;
          p_d        = '0;
          state_d    = S_WAIT_CNT;
        end else begin
          gray_valid = 1'b1;
          p_d        = p_q + ONE_A;
        end
      end
      // The watchdog spans both wait states; an arriving strobe beats the timeout.
      S_WAIT_CNT: begin
        wd_d = wd_q + WD_ONE;
        if (CNT_valid) begin
          cnt_d   = cnt_bus;
          state_d = S_WAIT_CODE;
        end else if (wd_q >= WD_LAST) begin
          err_code_d = 2'b10;
          state_d    = S_ERR;
        end else begin
          state_d = S_WAIT_CNT;
        end
      end
      S_WAIT_CODE: begin
        wd_d = wd_q + WD_ONE;
        if (code_valid) begin
          hc_d    = hc_bus;
          m_d     = m_bus;
          sym_d   = 3'd1;
          state_d = S_OUT;
        end else if (wd_q >= WD_LAST) begin
          err_code_d = 2'b10;
          state_d    = S_ERR;
        end else begin
          state_d = S_WAIT_CODE;
        end
      end
      S_OUT: begin
        if (res_ready && sym_q == 3'd6) begin
          done_d  = 1'b1;
          sym_d   = 3'd0;
          state_d = S_IDLE;
        end else if (res_ready) begin
          sym_d = sym_q + 3'd1;
        end else begin
          sym_d = sym_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      wd_q         <= '0;
      err_code_q   <= 2'b00;
      sym_q        <= 3'd0;
      cnt_q        <= 48'd0;
      hc_q         <= 48'd0;
      m_q          <= 48'd0;
      done_q       <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      wd_q         <= wd_d;
      err_code_q   <= err_code_d;
      sym_q        <= sym_d;
      cnt_q        <= cnt_d;
      hc_q         <= hc_d;
      m_q          <= m_d;
      done_q       <= done_d;
      core_reset_q <= (state_d == S_CLR);
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err        = (state_q == S_ERR);
  assign err_code   = err_code_q;
  assign done       = done_q;
  assign core_reset = core_reset_q;
  assign res_valid  = (state_q == S_OUT);
  assign res_sym    = sym_q;
  assign res_cnt    = sym_field(cnt_q, sym_q);
  assign res_hc     = sym_field(hc_q, sym_q);
  assign res_m      = sym_field(m_q, sym_q);

endmodule

// File: tb/tb_huffman_seq.sv
// Bench for huffman_seq: ROM + behavioural core model, table of jobs with a
// result scoreboard, plus hand-written reset sequences.
module tb_huffman_seq;

  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err, rom_rd, core_reset, gray_valid, res_valid;
  logic [1:0]  err_code;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_q = 8'd0;
  logic [7:0]  gray_data;
  logic        CNT_valid = 1'b0;
  logic        code_valid = 1'b0;
  logic [47:0] cnt_bus, hc_bus, m_bus;
  logic        res_ready = 1'b0;
  logic [2:0]  res_sym;
  logic [7:0]  res_cnt, res_hc, res_m;

  huffman_seq #(.N_PIX(100), .ADDR_W(7), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
    .core_reset(core_reset), .gray_valid(gray_valid), .gray_data(gray_data),
    .CNT_valid(CNT_valid), .cnt_bus(cnt_bus), .code_valid(code_valid),
    .hc_bus(hc_bus), .m_bus(m_bus), .res_valid(res_valid), .res_ready(res_ready),
    .res_sym(res_sym), .res_cnt(res_cnt), .res_hc(res_hc), .res_m(res_m)
  );

  always #5 clk = ~clk;

  // ROM with one injectable bad location
  logic [7:0] rom_mem [0:127];
  logic       bad_en = 1'b0;
  logic [6:0] bad_addr = 7'd0;
  logic [7:0] bad_val = 8'd0;

  always @(posedge clk)
    if (rom_rd) rom_q <= (bad_en && rom_addr == bad_addr) ? bad_val : rom_mem[rom_addr];

  // Core model: counts symbols, CNT_valid after the first idle cycle, codes 3 cycles later
  logic [7:0] cnt_m [0:7];
  logic       seen = 1'b0;
  logic [1:0] code_dly = 2'd0;
  logic       no_code = 1'b0;

  always @(posedge clk) begin
    if (core_reset) begin
      for (int k = 0; k < 8; k++) cnt_m[k] <= 8'd0;
      seen <= 1'b0; code_dly <= 2'd0; CNT_valid <= 1'b0; code_valid <= 1'b0;
    end else begin
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      if (gray_valid) begin
        cnt_m[gray_data[2:0]] <= cnt_m[gray_data[2:0]] + 8'd1;
        seen <= 1'b1;
      end else if (seen) begin
        seen <= 1'b0; CNT_valid <= 1'b1; code_dly <= 2'd3;
      end
      if (code_dly != 2'd0) begin
        code_dly <= code_dly - 2'd1;
        if (code_dly == 2'd1 && !no_code) code_valid <= 1'b1;
      end
    end
  end

  assign cnt_bus = {cnt_m[6], cnt_m[5], cnt_m[4], cnt_m[3], cnt_m[2], cnt_m[1]};
  assign hc_bus  = cnt_bus ^ {6{8'h5A}};
  assign m_bus   = ~cnt_bus;

  int n_cmp = 0;
  int n_bad = 0;
  logic [26:0] sb [$];
  logic [7:0]  exp_cnt [6] = '{8'd40, 8'd20, 8'd15, 8'd10, 8'd10, 8'd5};

  typedef struct {
    int         rmode;
    int         bad_pix;
    logic [7:0] bad_v;
    bit         no_code;
    bit         poke;
    logic [1:0] exp_code;
    int         exp_gv;
    int         exp_hs;
    int         exp_lat;
  } job_t;

  job_t jobs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {busy, done, err, err_code, rom_rd, rom_addr, gray_valid, gray_data,
               res_valid, res_sym, res_cnt, res_hc, res_m, core_reset},
        {50'd0, 1'b1});
  endtask

  task automatic run_job(input job_t j, input string tag);
    int n, stop_n, crst, gv, runs, first_gv, last_gv, first_rd, hs, dones, err_n, last_hs_n;
    logic [6:0]  first_addr;
    logic [26:0] act, exp, held;
    bit prev_gv, held_v, rv_seen, err_seen, fin;
    n = 1; stop_n = BUDGET; crst = 0; gv = 0; runs = 0; first_gv = -1; last_gv = -1;
    first_rd = -1; hs = 0; dones = 0; err_n = -1; last_hs_n = -1; first_addr = 7'd0;
    prev_gv = 1'b0; held_v = 1'b0; rv_seen = 1'b0; err_seen = 1'b0; fin = 1'b0; held = '0;
    bad_en = (j.bad_pix >= 0); bad_addr = 7'(j.bad_pix); bad_val = j.bad_v; no_code = j.no_code;
    if (j.exp_code == 2'b00)
      for (int k = 1; k <= 6; k++)
        sb.push_back({3'(k), exp_cnt[k-1], exp_cnt[k-1] ^ 8'h5A, ~exp_cnt[k-1]});
    start = 1'b1;
    step();
    while (n <= stop_n) begin
      res_ready = (j.rmode == 0) ? 1'b1 : (((n / 3) % 2) == 0);
      start = j.poke && ((gray_valid && gv == 10) || (res_valid && !rv_seen));
      if (n == 1) chk({tag, "_errcode_clr"}, err_code, 2'b00);
      if (core_reset) crst++;
      if (rom_rd && first_rd < 0) begin first_rd = n; first_addr = rom_addr; end
      if (gray_valid) begin
        if (!prev_gv) runs++;
        if (first_gv < 0) first_gv = n;
        gv++; last_gv = n;
      end
      prev_gv = gray_valid;
      if (res_valid) begin
        act = {res_sym, res_cnt, res_hc, res_m};
        if (held_v) chk({tag, "_stall_hold"}, act, held);
        rv_seen = 1'b1;
        if (res_ready) begin
          hs++; last_hs_n = n; held_v = 1'b0;
          exp = (sb.size() > 0) ? sb.pop_front() : 27'd0;
          chk({tag, "_result"}, act, exp);
        end else begin
          held_v = 1'b1; held = act;
        end
      end else begin
        held_v = 1'b0;
      end
      if (done && dones == 0) begin
        chk({tag, "_done_timing"}, n, last_hs_n + 1);
        chk({tag, "_done_idle"}, busy, 1'b0);
        stop_n = n + 2; fin = 1'b1;
      end
      if (done) dones++;
      if (err && !err_seen) begin
        err_seen = 1'b1; err_n = n;
        chk({tag, "_err_code"}, err_code, j.exp_code);
        chk({tag, "_err_busy"}, busy, 1'b0);
        stop_n = n + 1; fin = 1'b1;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk({tag, "_finished"}, fin, 1'b1);
    chk({tag, "_core_reset_cycles"}, crst, 2);
    chk({tag, "_gray_cycles"}, gv, j.exp_gv);
    chk({tag, "_gray_runs"}, runs, (j.exp_gv > 0) ? 1 : 0);
    if (j.exp_gv > 0) chk({tag, "_first_gray"}, first_gv, 4);
    chk({tag, "_first_rd"}, first_rd, 3);
    chk({tag, "_first_addr"}, first_addr, 7'd0);
    chk({tag, "_handshakes"}, hs, j.exp_hs);
    chk({tag, "_done_count"}, dones, (j.exp_code == 2'b00) ? 1 : 0);
    chk({tag, "_err_seen"}, err_seen, (j.exp_code != 2'b00));
    if (j.exp_lat >= 0) chk({tag, "_timeout_lat"}, err_n - (last_gv + 1), j.exp_lat);
    chk({tag, "_sb_left"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    job_t clean;
    for (int i = 0; i < 128; i++)
      rom_mem[i] = (i < 40) ? 8'd1 : (i < 60) ? 8'd2 : (i < 75) ? 8'd3 :
                   (i < 85) ? 8'd4 : (i < 95) ? 8'd5 : 8'd6;
    //           rmode bad  val    noc   poke  code   gv   hs  lat
    jobs[0] = '{0, -1, 8'd0,   1'b0, 1'b0, 2'b00, 100, 6, -1};
    jobs[1] = '{1, -1, 8'd0,   1'b0, 1'b0, 2'b00, 100, 6, -1};
    jobs[2] = '{0, 37, 8'd7,   1'b0, 1'b0, 2'b01, 37,  0, -1};
    jobs[3] = '{0, -1, 8'd0,   1'b0, 1'b0, 2'b00, 100, 6, -1};
    jobs[4] = '{0, -1, 8'd0,   1'b1, 1'b0, 2'b10, 100, 0, 20};
    jobs[5] = '{0, 0,  8'd0,   1'b0, 1'b0, 2'b01, 0,   0, -1};
    jobs[6] = '{0, 99, 8'd200, 1'b0, 1'b0, 2'b01, 99,  0, -1};
    jobs[7] = '{1, -1, 8'd0,   1'b0, 1'b1, 2'b00, 100, 6, -1};
    clean = jobs[0];

    reset = 1'b0;
    step();
    step();
    chk_reset_vals("reset_vals");
    reset = 1'b1;
    step();
    chk("idle_core_reset", {core_reset, busy}, 2'b00);

    for (int i = 0; i < 8; i++) run_job(jobs[i], $sformatf("job%0d", i));

    // Reset pulse in the middle of a stream, then replay from address 0
    bad_en = 1'b0; no_code = 1'b0; res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 200 && k < 50; c++) begin
      if (gray_valid) k++;
      step();
    end
    chk("midrst_streaming", {k, 1'b0, gray_valid}, {50, 1'b0, 1'b1});
    reset = 1'b0;
    step();
    chk_reset_vals("midrst_reset_vals");
    reset = 1'b1;
    step();
    chk("midrst_idle", {core_reset, busy}, 2'b00);
    step();
    run_job(clean, "replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
